ctrl_bus_arb: RTL

- Two-requester arbiter for the 21-bit address / 16-bit data register bus in the control subsystem.
- Requester 0 is the MDIO backend request port (psel/pwrite/paddr/pwdata, with pready/prdata returned). Requester 1 is a second host, such as the I2C/JTAG bridge.
- Grants are round-robin. The block drives a proper two-phase APB (setup, then access) to the register file.
- A single transaction is in flight at any time.

---
 rtl/ctrl_bus_arb_pkg.sv | 15 +
 rtl/ctrl_bus_rr_arb2.sv | 20 ++
 rtl/ctrl_bus_arb.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ctrl_bus_arb_pkg.sv
// Shared widths, defaults and FSM encoding for the control-bus arbiter.
package ctrl_bus_arb_pkg;

    localparam int          ADDR_W_DEF       = 21;
    localparam int          DATA_W_DEF       = 16;
    localparam logic [15:0] TIMEOUT_DATA_DEF = 16'hDEAD;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/ctrl_bus_rr_arb2.sv
// Combinational two-way round-robin picker; a tie goes to the requester that was not granted last.
module ctrl_bus_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_idx,
    output logic       gnt_vld
);

    always_comb begin
        gnt_vld = |req;
        gnt_idx = 1'b0;
        case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ~last_grant;
            default: gnt_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/ctrl_bus_arb.sv
// Two-requester round-robin arbiter driving a two-phase APB register bus, one transaction in flight.
// Define CTRL_BUS_ARB_TIMEOUT_EN to bound the access phase to TIMEOUT_CYC cycles.
module ctrl_bus_arb
    import ctrl_bus_arb_pkg::*;
#(
    parameter int                ADDR_W       = ADDR_W_DEF,
    parameter int                DATA_W       = DATA_W_DEF,
    parameter int                TIMEOUT_CYC  = 1024,
    parameter logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(TIMEOUT_DATA_DEF)
) (
    input  logic              clk_200m,
    input  logic              rst_200m,
    input  logic              m0_psel,
    input  logic              m0_pwrite,
    input  logic [ADDR_W-1:0] m0_paddr,
    input  logic [DATA_W-1:0] m0_pwdata,
    output logic              m0_pready,
    output logic [DATA_W-1:0] m0_prdata,
    input  logic              m1_psel,
    input  logic              m1_pwrite,
    input  logic [ADDR_W-1:0] m1_paddr,
    input  logic [DATA_W-1:0] m1_pwdata,
    output logic              m1_pready,
    output logic [DATA_W-1:0] m1_prdata,
    output logic              s_psel,
    output logic              s_penable,
    output logic              s_pwrite,
    output logic [ADDR_W-1:0] s_paddr,
    output logic [DATA_W-1:0] s_pwdata,
    input  logic              s_pready,
    input  logic [DATA_W-1:0] s_prdata,
    output logic              arb_busy,
    output logic              arb_owner,
    output logic              timeout_err
);

    typedef struct packed {
        logic              pwrite;
        logic [ADDR_W-1:0] paddr;
        logic [DATA_W-1:0] pwdata;
    } req_t;

    arb_state_t        r_state, w_state_nxt;
    req_t              r_req, w_req_nxt, w_req_m0, w_req_m1;
    logic              r_owner, w_owner_nxt;
    logic              r_last_grant, w_last_nxt;
    logic              r_s_psel, w_psel_nxt;
    logic              r_s_penable, w_penable_nxt;
    logic [1:0]        r_pready, w_pready_nxt;
    logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
    logic              r_busy, w_busy_nxt;
    logic              w_gnt_idx, w_gnt_vld;

`ifdef CTRL_BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_to_err, w_to_err_nxt;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^{TIMEOUT_DATA, 32'(TIMEOUT_CYC)};
`endif

    assign w_req_m0 = '{pwrite: m0_pwrite, paddr: m0_paddr, pwdata: m0_pwdata};
    assign w_req_m1 = '{pwrite: m1_pwrite, paddr: m1_paddr, pwdata: m1_pwdata};

    ctrl_bus_rr_arb2 u_rr_arb (
        .req        ({m1_psel, m0_psel}),
        .last_grant (r_last_grant),
        .gnt_idx    (w_gnt_idx),
        .gnt_vld    (w_gnt_vld)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_req_nxt     = r_req;
        w_owner_nxt   = r_owner;
        w_last_nxt    = r_last_grant;
        w_psel_nxt    = r_s_psel;
        w_penable_nxt = r_s_penable;
        w_pready_nxt  = 2'b00;
        w_rdata_nxt   = r_rdata;
`ifdef CTRL_BUS_ARB_TIMEOUT_EN
        w_cnt_nxt     = r_cnt;
        w_to_err_nxt  = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_vld) begin
                    w_req_nxt     = w_gnt_idx ? w_req_m1 : w_req_m0;
                    w_owner_nxt   = w_gnt_idx;
                    w_psel_nxt    = 1'b1;
                    w_penable_nxt = 1'b0;
                    w_state_nxt   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_penable_nxt = 1'b1;
                w_state_nxt   = ST_ACCESS;
            end
            ST_ACCESS: begin
                // A ready arriving on the expiry cycle takes priority over the timeout.
                if (s_pready) begin
                    w_rdata_nxt   = s_prdata;
                    w_psel_nxt    = 1'b0;
                    w_penable_nxt = 1'b0;
                    w_pready_nxt  = r_owner ? 2'b10 : 2'b01;
                    w_state_nxt   = ST_RESP;
`ifdef CTRL_BUS_ARB_TIMEOUT_EN
                    w_cnt_nxt     = '0;
                end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    w_rdata_nxt   = TIMEOUT_DATA;
                    w_psel_nxt    = 1'b0;
                    w_penable_nxt = 1'b0;
                    w_pready_nxt  = r_owner ? 2'b10 : 2'b01;
                    w_to_err_nxt  = 1'b1;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = ST_RESP;
                end else begin
                    w_cnt_nxt     = r_cnt + CNT_W'(1);
`endif
                end
            end
            ST_RESP: begin
                w_last_nxt  = r_owner;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk_200m) begin
        if (rst_200m) begin
            r_state      <= ST_IDLE;
            r_req        <= '0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_s_psel     <= 1'b0;
            r_s_penable  <= 1'b0;
            r_pready     <= 2'b00;
            r_rdata      <= '0;
            r_busy       <= 1'b0;
`ifdef CTRL_BUS_ARB_TIMEOUT_EN
            r_cnt        <= '0;
            r_to_err     <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_req        <= w_req_nxt;
            r_owner      <= w_owner_nxt;
            r_last_grant <= w_last_nxt;
            r_s_psel     <= w_psel_nxt;
            r_s_penable  <= w_penable_nxt;
            r_pready     <= w_pready_nxt;
            r_rdata      <= w_rdata_nxt;
            r_busy       <= w_busy_nxt;
`ifdef CTRL_BUS_ARB_TIMEOUT_EN
            r_cnt        <= w_cnt_nxt;
            r_to_err     <= w_to_err_nxt;
`endif
        end
    end

    assign s_psel    = r_s_psel;
    assign s_penable = r_s_penable;
    assign s_pwrite  = r_req.pwrite;
    assign s_paddr   = r_req.paddr;
    assign s_pwdata  = r_req.pwdata;
    assign m0_pready = r_pready[0];
    assign m1_pready = r_pready[1];
    assign m0_prdata = r_rdata;
    assign m1_prdata = r_rdata;
    assign arb_busy  = r_busy;
    assign arb_owner = r_owner;
`ifdef CTRL_BUS_ARB_TIMEOUT_EN
    assign timeout_err = r_to_err;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
